// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) engine producing Hi/Lo.
// Results land on hi/lo only at completion; a divide by zero leaves them untouched.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t           state, next_state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] mcand;
  logic             q_m1;
  logic             a_neg;
  logic             q_neg;
  logic             dz;
  logic             accept;
  logic             last;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             fits;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // A zero divisor still spends one cycle in DIV so done/div_zero appear after E1.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: next_state = start ? (op ? DIV : MULT) : IDLE;
      MULT:       if (last) next_state = DONE;
      DIV:        if (dz || last) next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == MULT) || (state == DIV);
    done     = (state == DONE);
    div_zero = (state == DONE) && dz;
  end

  always_comb begin
    m_ext     = {mcand[WIDTH-1], mcand};
    booth_sum = acc_hi;
    case ({acc_lo[0], q_m1})
      2'b01:   booth_sum = acc_hi + m_ext;
      2'b10:   booth_sum = acc_hi - m_ext;
      default: booth_sum = acc_hi;
    endcase
    rem_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    fits      = (rem_shift >= {1'b0, mcand});
    rem_diff  = rem_shift - {1'b0, mcand};
    abs_a     = a[WIDTH-1] ? -a : a;
    abs_b     = b[WIDTH-1] ? -b : b;
  end

  // acc_hi is one bit wider than WIDTH so Booth subtraction of the most-negative value cannot overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mcand  <= '0;
      q_m1   <= 1'b0;
      a_neg  <= 1'b0;
      q_neg  <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (accept) begin
      count  <= '0;
      acc_hi <= '0;
      q_m1   <= 1'b0;
      a_neg  <= a[WIDTH-1];
      q_neg  <= a[WIDTH-1] ^ b[WIDTH-1];
      dz     <= op && (b == '0);
      acc_lo <= op ? abs_a : a;
      mcand  <= op ? abs_b : b;
    end else if (state == MULT) begin
      if (!last) begin
        acc_hi <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        acc_lo <= {booth_sum[0], acc_lo[WIDTH-1:1]};
        q_m1   <= acc_lo[0];
        count  <= count + 1'b1;
      end else begin
        hi <= acc_hi[WIDTH-1:0];
        lo <= acc_lo;
      end
    end else if ((state == DIV) && !dz) begin
      if (!last) begin
        acc_hi <= fits ? rem_diff : rem_shift;
        acc_lo <= {acc_lo[WIDTH-2:0], fits};
        count  <= count + 1'b1;
      end else begin
        lo <= q_neg ? -acc_lo : acc_lo;
        hi <= a_neg ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
      end
    end
  end

endmodule
